// File: rtl/context_window_ctrl_if.sv
// Centre-tap timing stream into context_window_ctrl plus the measured timing,
// coordinate and qualification outputs it returns to the KLT datapath.
interface context_window_ctrl_if;
  logic        de_in;
  logic        h_sync_in;
  logic        v_sync_in;
  logic [10:0] h_size;
  logic [10:0] active_w;
  logic [10:0] active_h;
  logic [10:0] x;
  logic [10:0] y;
  logic        window_valid;
  logic        frame_start;
  logic        locked;
  logic [7:0]  relock_cnt;

  modport master (
    output de_in, h_sync_in, v_sync_in,
    input  h_size, active_w, active_h, x, y, window_valid, frame_start, locked, relock_cnt
  );

  modport slave (
    input  de_in, h_sync_in, v_sync_in,
    output h_size, active_w, active_h, x, y, window_valid, frame_start, locked, relock_cnt
  );
endinterface

// File: rtl/context_window_ctrl.sv
// Timing controller for the 3x3 context window: measures line/frame geometry, locks on it
// and qualifies interior pixels. Define CONTEXT_LOCK_CONFIRM_EN to require two matching good frames before lock.
module context_window_ctrl #(
  parameter int H_MAX    = 2047,
  parameter int V_MAX    = 2047,
  parameter int MIN_LINE = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  context_window_ctrl_if.slave  bus
);

  localparam logic [10:0] H_MAX_C    = 11'(H_MAX);
  localparam logic [10:0] V_MAX_C    = 11'(V_MAX);
  localparam logic [10:0] MIN_LINE_C = 11'(MIN_LINE);

`ifdef CONTEXT_LOCK_CONFIRM_EN
  typedef enum logic [1:0] {IDLE, MEASURE, MEASURE_CONFIRM, LOCKED} state_e;
`else
  typedef enum logic [1:0] {IDLE, MEASURE, LOCKED} state_e;
`endif

  state_e      state_q, state_d;
  logic        de_p_q, hs_p_q, vs_p_q;
  logic [10:0] per_cnt_q, per_cnt_d, per_ref_q, per_ref_d;
  logic        per_ok_q, per_ok_d, hs_seen_q, hs_seen_d;
  logic [10:0] w_cnt_q, w_cnt_d, w_ref_q, w_ref_d;
  logic        w_ok_q, w_ok_d;
  logic [10:0] l_cnt_q, l_cnt_d;
  logic        incons_q, incons_d;
  logic [10:0] h_size_q, h_size_d, active_w_q, active_w_d, active_h_q, active_h_d;
  logic [10:0] x_q, x_d, y_q, y_d;
  logic        window_valid_q, window_valid_d, frame_start_q, frame_start_d;
  logic        locked_q, locked_d;
  logic [7:0]  relock_q, relock_d;
`ifdef CONTEXT_LOCK_CONFIRM_EN
  logic [10:0] cand_per_q, cand_per_d, cand_w_q, cand_w_d, cand_h_q, cand_h_d;
`endif

  logic de_rise, de_fall, hs_rise, vs_rise, frame_good, same_vals;

  function automatic logic [10:0] sat_inc(input logic [10:0] v, input logic [10:0] max);
    return (v >= max) ? max : v + 11'd1;
  endfunction

  assign de_rise = bus.de_in & ~de_p_q;
  assign de_fall = ~bus.de_in & de_p_q;
  assign hs_rise = bus.h_sync_in & ~hs_p_q;
  assign vs_rise = bus.v_sync_in & ~vs_p_q;

  // A line still open at frame end (de_p_q high) is never counted, so the frame is rejected.
  assign frame_good = !incons_q && !de_p_q && per_ok_q && (per_ref_q >= MIN_LINE_C) &&
                      w_ok_q && (w_ref_q >= 11'd3) && (l_cnt_q >= 11'd3);
  assign same_vals  = (per_ref_q == h_size_q) && (w_ref_q == active_w_q) && (l_cnt_q == active_h_q);

  // Per-frame geometry measurement.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can infer a latch.
    per_cnt_d = per_cnt_q;
    per_ref_d = per_ref_q;
    per_ok_d  = per_ok_q;
    hs_seen_d = hs_seen_q;
    w_cnt_d   = w_cnt_q;
    w_ref_d   = w_ref_q;
    w_ok_d    = w_ok_q;
    l_cnt_d   = l_cnt_q;
    incons_d  = incons_q;
    if (vs_rise || state_q == IDLE) begin
      // New frame: an h_sync edge coinciding with v_sync opens its first line.
      per_cnt_d = hs_rise ? 11'd1 : 11'd0;
      hs_seen_d = hs_rise;
      per_ref_d = '0;
      per_ok_d  = 1'b0;
      w_cnt_d   = bus.de_in ? 11'd1 : 11'd0;
      w_ref_d   = '0;
      w_ok_d    = 1'b0;
      l_cnt_d   = '0;
      incons_d  = 1'b0;
    end else begin
      if (hs_rise) begin
        per_cnt_d = 11'd1;
        hs_seen_d = 1'b1;
        if (hs_seen_q) begin
          if (!per_ok_q) begin
            per_ref_d = per_cnt_q;
            per_ok_d  = 1'b1;
          end else if (per_cnt_q != per_ref_q) begin
            incons_d = 1'b1;
          end
        end
      end else begin
        per_cnt_d = sat_inc(per_cnt_q, H_MAX_C);
        if (per_cnt_d == H_MAX_C) incons_d = 1'b1;
      end
      if (bus.de_in) begin
        w_cnt_d = de_rise ? 11'd1 : sat_inc(w_cnt_q, H_MAX_C);
        if (w_cnt_d == H_MAX_C) incons_d = 1'b1;
      end
      if (de_fall) begin
        l_cnt_d = sat_inc(l_cnt_q, V_MAX_C);
        if (l_cnt_d == V_MAX_C) incons_d = 1'b1;
        if (!w_ok_q) begin
          w_ref_d = w_cnt_q;
          w_ok_d  = 1'b1;
        end else if (w_cnt_q != w_ref_q) begin
          incons_d = 1'b1;
        end
      end
    end
  end

  // Lock FSM and registered outputs.
  always_comb begin
    state_d    = state_q;
    locked_d   = locked_q;
    relock_d   = relock_q;
    h_size_d   = h_size_q;
    active_w_d = active_w_q;
    active_h_d = active_h_q;
`ifdef CONTEXT_LOCK_CONFIRM_EN
    cand_per_d = cand_per_q;
    cand_w_d   = cand_w_q;
    cand_h_d   = cand_h_q;
`endif
    case (state_q)
      IDLE: if (vs_rise) state_d = MEASURE;
      MEASURE: if (vs_rise && frame_good) begin
`ifdef CONTEXT_LOCK_CONFIRM_EN
        state_d    = MEASURE_CONFIRM;
        cand_per_d = per_ref_q;
        cand_w_d   = w_ref_q;
        cand_h_d   = l_cnt_q;
`else
        state_d    = LOCKED;
        locked_d   = 1'b1;
        h_size_d   = per_ref_q;
        active_w_d = w_ref_q;
        active_h_d = l_cnt_q;
`endif
      end
`ifdef CONTEXT_LOCK_CONFIRM_EN
      MEASURE_CONFIRM: if (vs_rise) begin
        if (frame_good && per_ref_q == cand_per_q && w_ref_q == cand_w_q && l_cnt_q == cand_h_q) begin
          state_d    = LOCKED;
          locked_d   = 1'b1;
          h_size_d   = per_ref_q;
          active_w_d = w_ref_q;
          active_h_d = l_cnt_q;
        end else begin
          state_d = MEASURE;
        end
      end
`endif
      LOCKED: if (vs_rise && !(frame_good && same_vals)) begin
        state_d  = MEASURE;
        locked_d = 1'b0;
        relock_d = (relock_q == 8'hFF) ? relock_q : relock_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase

    x_d = x_q;
    if (de_rise)        x_d = '0;
    else if (bus.de_in) x_d = sat_inc(x_q, H_MAX_C);
    y_d = y_q;
    if (vs_rise)        y_d = '0;
    else if (de_fall)   y_d = sat_inc(y_q, V_MAX_C);
    frame_start_d  = vs_rise;
    window_valid_d = locked_q && bus.de_in && (x_d != 11'd0) && (x_d <= active_w_q - 11'd2) &&
                     (y_d != 11'd0) && (y_d <= active_h_q - 11'd2);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= IDLE;
      de_p_q         <= 1'b0;
      hs_p_q         <= 1'b0;
      vs_p_q         <= 1'b0;
      per_cnt_q      <= '0;
      per_ref_q      <= '0;
      per_ok_q       <= 1'b0;
      hs_seen_q      <= 1'b0;
      w_cnt_q        <= '0;
      w_ref_q        <= '0;
      w_ok_q         <= 1'b0;
      l_cnt_q        <= '0;
      incons_q       <= 1'b0;
      h_size_q       <= '0;
      active_w_q     <= '0;
      active_h_q     <= '0;
      x_q            <= '0;
      y_q            <= '0;
      window_valid_q <= 1'b0;
      frame_start_q  <= 1'b0;
      locked_q       <= 1'b0;
      relock_q       <= '0;
`ifdef CONTEXT_LOCK_CONFIRM_EN
      cand_per_q     <= '0;
      cand_w_q       <= '0;
      cand_h_q       <= '0;
`endif
    end else begin
      // NOTE: non-blocking updates so every flop samples pre-edge values regardless of order.
      state_q        <= state_d;
      de_p_q         <= bus.de_in;
      hs_p_q         <= bus.h_sync_in;
      vs_p_q         <= bus.v_sync_in;
      per_cnt_q      <= per_cnt_d;
      per_ref_q      <= per_ref_d;
      per_ok_q       <= per_ok_d;
      hs_seen_q      <= hs_seen_d;
      w_cnt_q        <= w_cnt_d;
      w_ref_q        <= w_ref_d;
      w_ok_q         <= w_ok_d;
      l_cnt_q        <= l_cnt_d;
      incons_q       <= incons_d;
      h_size_q       <= h_size_d;
      active_w_q     <= active_w_d;
      active_h_q     <= active_h_d;
      x_q            <= x_d;
      y_q            <= y_d;
      window_valid_q <= window_valid_d;
      frame_start_q  <= frame_start_d;
      locked_q       <= locked_d;
      relock_q       <= relock_d;
`ifdef CONTEXT_LOCK_CONFIRM_EN
      cand_per_q     <= cand_per_d;
      cand_w_q       <= cand_w_d;
      cand_h_q       <= cand_h_d;
`endif
    end
  end

  assign bus.h_size       = h_size_q;
  assign bus.active_w     = active_w_q;
  assign bus.active_h     = active_h_q;
  assign bus.x            = x_q;
  assign bus.y            = y_q;
  assign bus.window_valid = window_valid_q;
  assign bus.frame_start  = frame_start_q;
  assign bus.locked       = locked_q;
  assign bus.relock_cnt   = relock_q;

endmodule

// File: doc/context_window_ctrl.md
Name: context_window_ctrl

Overview:
- Timing controller for the 3x3 context datapath.
- Watches the centre-tap stream (de/h_sync/v_sync), measures line period, active width and active line count, and supplies the h_size value that configures the line-delay BRAMs.
- Tracks centre-pixel x/y coordinates and qualifies the window as interior (no border taps) once timing is locked.
- Downstream KLT stages use window_valid instead of raw de.

Parameters:
- H_MAX, 2047, max countable clocks per line / pixels per line; counters saturate here.
- V_MAX, 2047, max countable active lines per frame.
- MIN_LINE, 16, minimum accepted line period in clocks.

Ports:
- clk  in  1  pixel clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset
- de_in  in  1  data enable of centre tap
- h_sync_in  in  1  horizontal sync, active high
- v_sync_in  in  1  vertical sync, active high
- h_size  out  11  measured line period in clocks (delay-line length)
- active_w  out  11  measured active pixels per line
- active_h  out  11  measured active lines per frame
- x  out  11  column of current centre pixel
- y  out  11  row of current centre pixel
- window_valid  out  1  centre pixel is interior and timing locked
- frame_start  out  1  one-cycle pulse on v_sync rising edge
- locked  out  1  timing measured and stable
- relock_cnt  out  8  saturating count of lock losses

Behaviour:
- Reset: rst=0 at a rising edge clears every register. All outputs are 0 and state = IDLE. Reset mid-frame discards the measurement in progress.
- Edge detection: registered previous de/h_sync/v_sync, reset to 0. Rising edge = prev 0, now 1.
- All outputs are registered. x/y/window_valid reflect the input sample of the previous cycle (latency 1).
- Per-frame measurement (runs in MEASURE and LOCKED):
  - per_cnt counts clocks between h_sync rising edges. The first period of a frame is the reference; every later period must equal it, else the frame is marked inconsistent.
  - w_cnt counts de=1 cycles and latches on the de falling edge. All lines must match, else the frame is inconsistent.
  - l_cnt increments on each de falling edge.
  - Any counter reaching H_MAX/V_MAX saturates and marks the frame inconsistent.
- Frame end = v_sync rising edge. The frame is good if it is consistent, period >= MIN_LINE, width >= 3 and lines >= 3.
- FSM:
  - IDLE: on v_sync rising -> MEASURE; clear counters.
  - MEASURE: at frame end, if good -> LOCKED; load h_size/active_w/active_h; locked=1. If not good, remain in MEASURE.
  - LOCKED: at frame end, if good and all three values equal the stored values -> stay. Otherwise -> MEASURE; locked=0; relock_cnt+1, saturating at 255. h_size keeps its last value until the next lock.
- x: 0 at the de rising edge, +1 per de=1 cycle. y: 0 at v_sync rising, +1 per de falling edge. Both hold when de=0.
- window_valid = locked & de & (1 <= x <= active_w-2) & (1 <= y <= active_h-2). It is always 0 outside LOCKED.
- frame_start pulses in every state except during reset.
- Simultaneous v_sync and h_sync rising edges: the frame-end evaluation uses the values from before the edge; the new line then begins.
- de still high at v_sync rising: the open line is not counted; the frame is inconsistent.

Optional Feature:
- Macro: CONTEXT_LOCK_CONFIRM_EN.
- Defined: MEASURE requires two consecutive good frames with identical values before entering LOCKED. This adds a MEASURE_CONFIRM state, which goes to MEASURE on mismatch. The LOCKED -> MEASURE drop still occurs on the first bad frame.
- Undefined: a single good frame locks, as described in Behaviour.

Test Plan:
- Lock: period 20 clks, de 8 clks/line, 6 lines/frame, v_sync pulse -> after the 2nd v_sync: locked=1, h_size=20, active_w=8, active_h=6, relock_cnt=0.
- Interior mask: locked stream as above -> window_valid=1 only for x=1..6, y=1..4, i.e. 24 pulses per frame. frame_start pulses once per frame.
- Width glitch: line 3 of a locked frame carries de for 7 clks -> at the next v_sync, locked=0 and relock_cnt=1. The following clean frame relocks.
- Short line: period 10 < MIN_LINE -> locked never asserts and window_valid stays 0.
- Reset mid-frame: rst=0 for 1 cycle during line 2 -> next cycle all outputs are 0 and state = IDLE. Lock returns after 2 more v_sync edges.
- With CONTEXT_LOCK_CONFIRM_EN: clean stream -> locked asserts at the 3rd v_sync, not the 2nd.
